// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit RISC CPU sequencer.
//   - opcode constants, instruction field bit positions
//   - sequencer state encoding
//   - default reset PC
package cpu_pkg;

  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;
  localparam logic [2:0] OP_NOP1 = 3'b101;
  localparam logic [2:0] OP_NOP2 = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Instruction word layout: [15:13] opcode, [12] imm flag, [11:10] rd,
  // [9:8] rs, [7:0] imm8.
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int IMM_FLAG = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 10;
  localparam int RS_MSB   = 9;
  localparam int RS_LSB   = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_WB    = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  // Opcodes 000..100 go through the ALU and produce a register write.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// regfile4x8: four 8-bit registers, two asynchronous read ports and one
// synchronous write port; all registers clear on synchronous reset.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_we/i_waddr/i_wdata  write port (takes effect at the rising edge)
//   i_raddr_a/o_rdata_a   read port A (combinational)
//   i_raddr_b/o_rdata_b   read port B (combinational)
module regfile4x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [1:0] i_raddr_a,
  output logic [7:0] o_rdata_a,
  input  logic [1:0] i_raddr_b,
  output logic [7:0] o_rdata_b
);

  logic [7:0] r_mem [4];

  // Register storage: reset clears every entry and has priority over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH / EXEC / WB controller of the 8-bit CPU.
// Fetches 16-bit instructions over a req/ack handshake, owns the 4x8
// register file, drives the external combinational ALU and writes its
// result back.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req/imem_addr                fetch request and address (= PC)
//   imem_ack/imem_rdata               fetch completion and instruction word
//   alu_opcode/alu_op1/alu_op2        ALU inputs (meaningful in EXEC)
//   alu_result                        ALU output
//   wb_valid/wb_rd/wb_data            register write of the current cycle
//   halted                            core stopped by HALT
//   pc                                current program counter
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  alu_op1,
  output logic [7:0]  alu_op2,
  input  logic [7:0]  alu_result,
  output logic        wb_valid,
  output logic [1:0]  wb_rd,
  output logic [7:0]  wb_data,
  output logic        halted,
  output logic [7:0]  pc
);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic [7:0]  r_result;

  logic        w_fetch_take;
  logic        w_capture;
  logic        w_wb_we;

  logic [2:0]  w_opcode;
  logic        w_imm_flag;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs;
  logic [7:0]  w_imm8;
  logic [7:0]  w_rd_val;
  logic [7:0]  w_rs_val;

  assign w_opcode   = r_ir[OPC_MSB:OPC_LSB];
  assign w_imm_flag = r_ir[IMM_FLAG];
  assign w_rd       = r_ir[RD_MSB:RD_LSB];
  assign w_rs       = r_ir[RS_MSB:RS_LSB];
  assign w_imm8     = r_ir[IMM_MSB:IMM_LSB];

  regfile4x8 u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_wb_we),
    .i_waddr   (w_rd),
    .i_wdata   (r_result),
    .i_raddr_a (w_rd),
    .o_rdata_a (w_rd_val),
    .i_raddr_b (w_rs),
    .o_rdata_b (w_rs_val)
  );

  // ALU inputs follow IR and the register file in every state.
  assign alu_opcode = w_opcode;
  assign alu_op1    = w_rd_val;
  assign alu_op2    = w_imm_flag ? w_imm8 : w_rs_val;

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign wb_valid   = w_wb_we;
  assign wb_rd      = w_rd;
  assign wb_data    = r_result;

  // Next-state and per-state control decode.
  always_comb begin
    w_next_state = r_state;
    w_fetch_take = 1'b0;
    w_capture    = 1'b0;
    w_wb_we      = 1'b0;
    imem_req     = 1'b0;
    halted       = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_fetch_take = 1'b1;
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (is_alu_op(w_opcode)) begin
          w_capture    = 1'b1;
          w_next_state = ST_WB;
        end else if (w_opcode == OP_HALT) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_WB: begin
        w_wb_we      = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_HALT: begin
        halted       = 1'b1;
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // State, PC, IR and result register; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= 16'h0000;
      r_result <= 8'h00;
    end else begin
      r_state <= w_next_state;
      if (w_fetch_take) begin
        r_ir <= imem_rdata;
        r_pc <= r_pc + 8'd1;
      end
      if (w_capture) begin
        r_result <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two instances (RESET_PC 00 and FF), a bench ALU
// and instruction memory, and an instruction-level reference model that
// predicts fetch, write-back and halt timing per cycle.
module tb_cpu_sequencer;

  localparam int NEVER = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_ack = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] mem [256];

  logic req0, req1, wbv0, wbv1, hlt0, hlt1;
  logic [7:0] addr0, addr1, a0, a1, b0, b1, res0, res1, wbd0, wbd1, pc0, pc1;
  logic [15:0] rdata0, rdata1;
  logic [2:0] opc0, opc1;
  logic [1:0] wbrd0, wbrd1;

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return y;
      default: return 8'h00;
    endcase
  endfunction

  assign rdata0 = mem[addr0];
  assign rdata1 = mem[addr1];
  assign res0 = alu_fn(opc0, a0, b0);
  assign res1 = alu_fn(opc1, a1, b1);

  cpu_sequencer #(.RESET_PC(8'h00)) dut0 (
    .clk(clk), .rst(rst), .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack),
    .imem_rdata(rdata0), .alu_opcode(opc0), .alu_op1(a0), .alu_op2(b0),
    .alu_result(res0), .wb_valid(wbv0), .wb_rd(wbrd0), .wb_data(wbd0),
    .halted(hlt0), .pc(pc0)
  );

  cpu_sequencer #(.RESET_PC(8'hFF)) dut1 (
    .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack),
    .imem_rdata(rdata1), .alu_opcode(opc1), .alu_op1(a1), .alu_op2(b1),
    .alu_result(res1), .wb_valid(wbv1), .wb_rd(wbrd1), .wb_data(wbd1),
    .halted(hlt1), .pc(pc1)
  );

  logic s_req, s_wbv, s_hlt;
  logic [7:0] s_addr, s_a, s_b, s_wbd, s_pc;
  logic [2:0] s_opc;
  logic [1:0] s_wbrd;
  assign s_req  = sel ? req1  : req0;
  assign s_wbv  = sel ? wbv1  : wbv0;
  assign s_hlt  = sel ? hlt1  : hlt0;
  assign s_addr = sel ? addr1 : addr0;
  assign s_a    = sel ? a1    : a0;
  assign s_b    = sel ? b1    : b0;
  assign s_wbd  = sel ? wbd1  : wbd0;
  assign s_pc   = sel ? pc1   : pc0;
  assign s_opc  = sel ? opc1  : opc0;
  assign s_wbrd = sel ? wbrd1 : wbrd0;

  int checks = 0;
  int errors = 0;
  int k = 0;

  // Reference model state (instruction level plus event schedule).
  bit         mv = 1'b0;
  logic [7:0] m_pc;
  logic [7:0] m_reg [4];
  bit         m_halt;
  int         nreq, halt_cyc, wb_cyc, ex_cyc;
  logic [1:0] wb_rd_e;
  logic [7:0] wb_d_e, ex_a, ex_b;
  logic [2:0] ex_opc;
  logic [9:0] wb_log [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset();
    mv = 1'b1;
    m_pc = sel ? 8'hFF : 8'h00;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_halt = 1'b0;
    nreq = k + 1;
    halt_cyc = NEVER;
    wb_cyc = -1;
    ex_cyc = -1;
  endtask

  task automatic model_fetch();
    logic [15:0] w;
    logic [2:0] op;
    logic [1:0] rd, rs;
    logic [7:0] y;
    w  = mem[m_pc];
    op = w[15:13];
    rd = w[11:10];
    rs = w[9:8];
    y  = w[12] ? w[7:0] : m_reg[rs];
    ex_cyc = k + 1;
    ex_opc = op;
    ex_a = m_reg[rd];
    ex_b = y;
    m_pc = m_pc + 8'd1;
    if (op <= 3'd4) begin
      m_reg[rd] = alu_fn(op, m_reg[rd], y);
      wb_cyc = k + 2;
      wb_rd_e = rd;
      wb_d_e = m_reg[rd];
      nreq = k + 3;
    end else if (op == 3'd7) begin
      m_halt = 1'b1;
      halt_cyc = k + 2;
      nreq = NEVER;
    end else begin
      nreq = k + 2;
    end
  endtask

  // One cycle: compare this cycle's outputs against the model, then drive
  // rst/ack for the coming edge and advance the model accordingly.
  task automatic step(input logic r, input logic a);
    bit exp_req;
    @(negedge clk);
    k++;
    exp_req = !m_halt && (k >= nreq);
    if (mv) begin
      chk("imem_req", 32'(s_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", 32'(s_addr), 32'(m_pc));
      chk("pc", 32'(s_pc), 32'(m_pc));
      chk("wb_valid", 32'(s_wbv), 32'(k == wb_cyc));
      if (k == wb_cyc) begin
        chk("wb_rd", 32'(s_wbrd), 32'(wb_rd_e));
        chk("wb_data", 32'(s_wbd), 32'(wb_d_e));
      end
      chk("halted", 32'(s_hlt), 32'(m_halt && (k >= halt_cyc)));
      if (k == ex_cyc) begin
        chk("alu_opcode", 32'(s_opc), 32'(ex_opc));
        chk("alu_op1", 32'(s_a), 32'(ex_a));
        chk("alu_op2", 32'(s_b), 32'(ex_b));
      end
      if (s_wbv) wb_log.push_back({s_wbrd, s_wbd});
    end
    rst = r;
    imem_ack = a;
    if (r) model_reset();
    else if (mv && exp_req && a) model_fetch();
  endtask

  task automatic start(input logic s);
    sel = s;
    mv = 1'b0;
    wb_log.delete();
    step(1'b1, 1'b0);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  initial begin
    logic [15:0] w;

    // Reset and zero-wait fetch of ADD R1,#05.
    fill_halt();
    mem[0] = 16'h1405;
    start(1'b0);
    step(1'b0, 1'b1);
    chk("rst_req", 32'(s_req), 32'd1);
    chk("rst_addr", 32'(s_addr), 32'h00);
    chk("rst_wbv", 32'(s_wbv), 32'd0);
    chk("rst_halted", 32'(s_hlt), 32'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("add_wbv", 32'(s_wbv), 32'd1);
    chk("add_rd", 32'(s_wbrd), 32'd1);
    chk("add_data", 32'(s_wbd), 32'h05);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // Register path with wrap: MOV R0,#FF; MOV R2,#01; ADD R0,R2; SUB R0,R2.
    fill_halt();
    mem[0] = 16'h90FF;
    mem[1] = 16'h9801;
    mem[2] = 16'h0200;
    mem[3] = 16'h2200;
    start(1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
    chk("regpath_count", 32'(wb_log.size()), 32'd4);
    if (wb_log.size() == 4) begin
      chk("regpath_w0", 32'(wb_log[0]), 32'h0FF);
      chk("regpath_w1", 32'(wb_log[1]), 32'h201);
      chk("regpath_w2", 32'(wb_log[2]), 32'h000);
      chk("regpath_w3", 32'(wb_log[3]), 32'h0FF);
    end

    // Wait states: ack held low for three cycles.
    fill_halt();
    mem[0] = 16'h9CAA;
    start(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("wait_req", 32'(s_req), 32'd1);
      chk("wait_addr", 32'(s_addr), 32'h00);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("wait_pc", 32'(s_pc), 32'h01);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("wait_pc_once", 32'(s_pc), 32'h01);

    // NOP then HALT, then acks while halted.
    fill_halt();
    mem[0] = 16'hA000;
    mem[1] = 16'hE000;
    start(1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("nop_next_addr", 32'(s_addr), 32'h01);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("halt_halted", 32'(s_hlt), 32'd1);
    chk("halt_req", 32'(s_req), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("halt_pc", 32'(s_pc), 32'h02);
    chk("nop_no_wb", 32'(wb_log.size()), 32'd0);

    // PC wrap from RESET_PC = FF.
    fill_halt();
    mem[255] = 16'hA000;
    start(1'b1);
    step(1'b0, 1'b1);
    chk("wrap_first", 32'(s_addr), 32'hFF);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("wrap_second", 32'(s_addr), 32'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // Reset during WB of MOV R3,#AA; then MOV R0,R3 must read 00.
    fill_halt();
    mem[0] = 16'h9CAA;
    start(1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("midrst_wbv", 32'(s_wbv), 32'd1);
    mem[0] = 16'h8300;
    step(1'b0, 1'b1);
    chk("midrst_pc", 32'(s_pc), 32'h00);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("midrst_rd", 32'(s_wbrd), 32'd0);
    chk("midrst_data", 32'(s_wbd), 32'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // Randomized programs, ack timing and occasional resets.
    for (int round = 0; round < 8; round++) begin
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:13] == 3'b111 && $urandom_range(0, 7) != 0) w[15:13] = 3'b100;
        mem[i] = w;
      end
      start(1'($urandom_range(0, 1)));
      for (int i = 0; i < 400; i++) begin
        step(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
